// File: rtl/ttc_sync_ctrl_if.sv
// ttc_sync_ctrl_if: TTC strobe, configuration and status bundle for the sync controller
interface ttc_sync_ctrl_if #(parameter int MXBXN = 12);
  logic             ttc_bx0_in;
  logic             ttc_resync_in;
  logic             sw_resync_req;
  logic             auto_resync_en;
  logic [MXBXN-1:0] bxn_offset_cfg;
  logic             bxn_sync_err;
  logic             cnt_reset;
  logic             ttc_resync;
  logic             ttc_bx0;
  logic [MXBXN-1:0] bxn_offset;
  logic [2:0]       state;
  logic             locked;
  logic [31:0]      bx0_cnt;
  logic [15:0]      err_cnt;
  logic [1:0]       retry_cnt;
  modport master (
    output ttc_bx0_in, ttc_resync_in, sw_resync_req, auto_resync_en, bxn_offset_cfg, bxn_sync_err, cnt_reset,
    input  ttc_resync, ttc_bx0, bxn_offset, state, locked, bx0_cnt, err_cnt, retry_cnt
  );
  modport slave (
    input  ttc_bx0_in, ttc_resync_in, sw_resync_req, auto_resync_en, bxn_offset_cfg, bxn_sync_err, cnt_reset,
    output ttc_resync, ttc_bx0, bxn_offset, state, locked, bx0_cnt, err_cnt, retry_cnt
  );
endinterface

// File: rtl/ttc_sync_ctrl.sv
// ttc_sync_ctrl: TTC resync/bx0 lock controller with automatic retry and statistics
module ttc_sync_ctrl #(
  parameter int               MXBXN     = 12,
  parameter logic [MXBXN-1:0] LHC_CYCLE = 12'd3564,
  parameter int               LOCK_BX0S = 4,
  parameter int               MAX_RETRY = 3
) (
  input logic            clock,
  input logic            reset,
  ttc_sync_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESYNC   = 3'd1,
    WAIT_BX0 = 3'd2,
    CHECK    = 3'd3,
    LOCKED   = 3'd4,
    ERROR    = 3'd5
  } state_t;
  localparam int TMO = 2 * int'(LHC_CYCLE) - 1;
  localparam int GW = $clog2(LOCK_BX0S + 1);
  localparam logic [MXBXN-1:0] OFF_MAX = MXBXN'(int'(LHC_CYCLE) - 1);
  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       chk_q;
  logic [12:0]      timer_q;
  logic             ttc_bx0_q, ttc_resync_q, locked_q;
  logic [MXBXN-1:0] offset_q;
  logic [31:0]      bx0_cnt_q;
  logic [15:0]      err_cnt_q;
  logic             rs, active, strobe, timeout, fault, err_inc;
  assign rs      = bus.ttc_resync_in | bus.sw_resync_req;
  assign active  = state_q inside {WAIT_BX0, CHECK, LOCKED};
  assign strobe  = chk_q[1];
  assign timeout = active && !bus.ttc_bx0_in && timer_q == 13'(TMO - 1);
  assign fault   = timeout || (strobe && bus.bxn_sync_err && state_q inside {CHECK, LOCKED});
  // a resync request swallows a coincident fault so it is never counted
  assign err_inc = fault && !rs && err_cnt_q != '1;
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    good_d  = (state_q == RESYNC) ? '0 : good_q;
    if (rs) begin
      state_d = RESYNC;
      retry_d = '0;
    end else if (fault) begin
      if (bus.auto_resync_en && int'(retry_q) < MAX_RETRY) begin
        state_d = RESYNC;
        retry_d = retry_q + 2'd1;
      end else begin
        state_d = ERROR;
      end
    end else begin
      case (state_q)
        RESYNC:   state_d = WAIT_BX0;
        WAIT_BX0: state_d = bus.ttc_bx0_in ? CHECK : WAIT_BX0;
        CHECK: if (strobe) begin
          good_d  = good_q + GW'(1);
          state_d = (good_q == GW'(LOCK_BX0S - 1)) ? LOCKED : CHECK;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      good_q       <= '0;
      retry_q      <= '0;
      chk_q        <= '0;
      timer_q      <= '0;
      ttc_bx0_q    <= 1'b0;
      ttc_resync_q <= 1'b0;
      locked_q     <= 1'b0;
      offset_q     <= '0;
      bx0_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      retry_q      <= retry_d;
      chk_q        <= {chk_q[0], bus.ttc_bx0_in};
      timer_q      <= (active && !bus.ttc_bx0_in) ? timer_q + 13'd1 : '0;
      ttc_bx0_q    <= bus.ttc_bx0_in;
      ttc_resync_q <= state_q == RESYNC;
      locked_q     <= state_d == LOCKED;
      if (state_q == RESYNC) offset_q <= (bus.bxn_offset_cfg > OFF_MAX) ? OFF_MAX : bus.bxn_offset_cfg;
      bx0_cnt_q    <= bus.cnt_reset ? '0 : bx0_cnt_q + 32'(bus.ttc_bx0_in);
      err_cnt_q    <= bus.cnt_reset ? '0 : err_cnt_q + 16'(err_inc);
    end
  end
  assign bus.ttc_bx0    = ttc_bx0_q;
  assign bus.ttc_resync = ttc_resync_q;
  assign bus.bxn_offset = offset_q;
  assign bus.state      = state_q;
  assign bus.locked     = locked_q;
  assign bus.bx0_cnt    = bx0_cnt_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.retry_cnt  = retry_q;
endmodule
